// File: rtl/rx_line_count_fifo.sv
// rx_line_count_fifo
// Store-and-forward RX packet FIFO between one MAC RX stream and one
// load-balancer input. A packet is buffered whole while its length in
// lines is counted. The count then travels with every output beat of
// that packet. Errored, oversized and non-fitting packets are discarded
// whole, because the MAC cannot be held off.
//
// Ports
//   clk, rst                 : single clock, synchronous active-high reset
//   s_axis_*                 : MAC RX stream (tuser = bad frame, sampled on tlast)
//   m_axis_*                 : packet stream to the load balancer
//   m_axis_line_count        : line count of the packet currently on m_axis
//   pkt_count / drop_count   : wrapping committed / dropped packet counters
module rx_line_count_fifo #(
    parameter int DATA_WIDTH     = 512,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int DEPTH          = 1024,
    parameter int LEN_DEPTH      = 32,
    parameter int RX_LINES_WIDTH = 13,
    parameter int MAX_LINES      = 200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [STRB_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [STRB_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [RX_LINES_WIDTH-1:0] m_axis_line_count,
    output logic [31:0]               pkt_count,
    output logic [31:0]               drop_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam int LPW = LAW + 1;
    localparam int RW  = DATA_WIDTH + STRB_WIDTH + 1;

    localparam logic [PW-1:0]             DEPTH_P     = PW'(DEPTH);
    localparam logic [LPW-1:0]            LEN_DEPTH_P = LPW'(LEN_DEPTH);
    localparam logic [RX_LINES_WIDTH-1:0] MAX_P       = RX_LINES_WIDTH'(MAX_LINES);
    localparam logic [RX_LINES_WIDTH-1:0] ONE_L       = RX_LINES_WIDTH'(1);

    // Each RAM line holds {tlast, tkeep, tdata}
    logic [RW-1:0]             mem     [DEPTH];
    logic [RX_LINES_WIDTH-1:0] len_mem [LEN_DEPTH];

    logic [PW-1:0]             wr_ptr, wr_commit, rd_ptr;
    logic [RX_LINES_WIDTH-1:0] cur_lines;
    logic                      drop_flag;
    logic [31:0]               pkt_cnt_q, drop_cnt_q;

    // The length FIFO has two read pointers: len_iss follows the RAM read
    // issue, len_rd follows the output handshake and frees the entry.
    logic [LPW-1:0]            len_wr, len_iss, len_rd;
    logic [RX_LINES_WIDTH-1:0] rd_beat;

    // Two-entry output stage, entry 0 drives m_axis
    logic [RW-1:0]             out_w  [2];
    logic [RX_LINES_WIDTH-1:0] out_lc [2];
    logic [1:0]                out_cnt;

    logic accept, buf_full, len_full, drop_beat, do_write, drop_pkt;
    logic pkt_avail, pop, issue, issue_last, issue_slot;
    logic [RX_LINES_WIDTH-1:0] issue_lc;

    assign s_axis_tready = !rst;

    // Write-side decisions for the beat on the input this cycle
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign buf_full  = (wr_ptr - rd_ptr) == DEPTH_P;
    assign len_full  = (len_wr - len_rd) == LEN_DEPTH_P;
    assign drop_beat = drop_flag || buf_full || (cur_lines == MAX_P);
    assign do_write  = accept && !drop_beat;
    assign drop_pkt  = drop_beat || s_axis_tuser || len_full;

    // Read side: only committed packets are read, so no address collides
    // with the write port. A read is issued whenever the output stage has,
    // or is freeing, a slot.
    assign pkt_avail  = (len_iss != len_wr) && (rd_ptr != wr_commit);
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign issue      = pkt_avail && ((out_cnt != 2'd2) || pop);
    assign issue_lc   = len_mem[len_iss[LAW-1:0]];
    assign issue_last = (rd_beat + ONE_L) == issue_lc;
    assign issue_slot = (out_cnt == 2'd2) || ((out_cnt == 2'd1) && !pop);

    // RAM write port; a line written for a packet that is later dropped is
    // simply overwritten once wr_ptr rewinds.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (accept && s_axis_tlast && !drop_pkt) begin
            len_mem[len_wr[LAW-1:0]] <= cur_lines + ONE_L;
        end
    end

    // Packet accounting: speculative writes, rewind on drop, commit on tlast
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            wr_commit  <= '0;
            cur_lines  <= '0;
            drop_flag  <= 1'b0;
            len_wr     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                cur_lines <= '0;
                drop_flag <= 1'b0;
                if (drop_pkt) begin
                    wr_ptr     <= wr_commit;
                    drop_cnt_q <= drop_cnt_q + 32'd1;
                end else begin
                    wr_ptr    <= wr_ptr + PW'(1);
                    wr_commit <= wr_ptr + PW'(1);
                    len_wr    <= len_wr + LPW'(1);
                    pkt_cnt_q <= pkt_cnt_q + 32'd1;
                end
            end else if (drop_beat) begin
                drop_flag <= 1'b1;
                wr_ptr    <= wr_commit;
            end else begin
                wr_ptr    <= wr_ptr + PW'(1);
                cur_lines <= cur_lines + ONE_L;
            end
        end
    end

    // Read pointers and the output stage. On a pop, entry 1 shifts down;
    // a new RAM line lands in the first slot that is free after the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            len_iss   <= '0;
            len_rd    <= '0;
            rd_beat   <= '0;
            out_cnt   <= '0;
            out_w[0]  <= '0;
            out_w[1]  <= '0;
            out_lc[0] <= '0;
            out_lc[1] <= '0;
        end else begin
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (issue_last) begin
                    len_iss <= len_iss + LPW'(1);
                    rd_beat <= '0;
                end else begin
                    rd_beat <= rd_beat + ONE_L;
                end
            end
            if (pop && m_axis_tlast) begin
                len_rd <= len_rd + LPW'(1);
            end
            if (pop) begin
                out_w[0]  <= out_w[1];
                out_lc[0] <= out_lc[1];
            end
            if (issue) begin
                out_w[issue_slot]  <= mem[rd_ptr[AW-1:0]];
                out_lc[issue_slot] <= issue_lc;
            end
            out_cnt <= out_cnt + {1'b0, issue} - {1'b0, pop};
        end
    end

    assign m_axis_tvalid     = out_cnt != 2'd0;
    assign m_axis_tlast      = out_w[0][RW-1];
    assign m_axis_tkeep      = out_w[0][DATA_WIDTH +: STRB_WIDTH];
    assign m_axis_tdata      = out_w[0][DATA_WIDTH-1:0];
    assign m_axis_line_count = out_lc[0];
    assign pkt_count         = pkt_cnt_q;
    assign drop_count        = drop_cnt_q;

endmodule

// File: doc/rx_line_count_fifo.md
# rx_line_count_fifo

Per-interface store-and-forward RX packet FIFO between an Ethernet MAC RX stream and the load balancer's `rx_axis_*` inputs. Each packet is buffered in full, and its length in 512-bit lines is measured as it arrives. The line count is presented on `m_axis_line_count` for every beat of the packet, so the load balancer knows the packet size at the first beat. Errored, oversized and non-fitting packets are dropped whole, because the MAC cannot be back-pressured. One instance per interface; three instances feed the 3-port load balancer.

## Interface
Parameters:
- `DATA_WIDTH`, 512: data bus width.
- `STRB_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `DEPTH`, 1024: data buffer depth in lines; must be a power of 2.
- `LEN_DEPTH`, 32: length-FIFO entries, i.e. the maximum number of committed packets held; must be a power of 2.
- `RX_LINES_WIDTH`, 13: width of the line count.
- `MAX_LINES`, 200: largest accepted packet in lines; must be ≤ `DEPTH` and < 2^`RX_LINES_WIDTH`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `s_axis_tdata` in `DATA_WIDTH`, `s_axis_tkeep` in `STRB_WIDTH`, `s_axis_tvalid` in 1, `s_axis_tlast` in 1: MAC RX stream.
- `s_axis_tuser`, in, 1: bad-frame flag; sampled on the tlast beat only.
- `s_axis_tready`, out, 1: 0 during reset, 1 otherwise.
- `m_axis_tdata` out `DATA_WIDTH`, `m_axis_tkeep` out `STRB_WIDTH`, `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1: stream to the load balancer.
- `m_axis_line_count`, out, `RX_LINES_WIDTH`: beat count of the current output packet; held constant on every beat of that packet.
- `pkt_count`, out, 32: committed packets; wraps.
- `drop_count`, out, 32: dropped packets; wraps.

## Operation
- Data RAM: `DEPTH` × (`DATA_WIDTH` + `STRB_WIDTH` + 1), storing tlast with each line.
- Pointers are `$clog2(DEPTH)+1` bits wide; the MSB distinguishes full from empty on wrap.
- Write side uses three pointers and a flag:
  - `wr_ptr`: speculative write pointer.
  - `wr_commit`: committed write pointer.
  - `rd_ptr`: read pointer.
  - `cur_lines`: lines of the current packet, width `RX_LINES_WIDTH`.
  - `drop_flag`: current packet is being dropped.
- Each accepted beat (`tvalid && tready`) is handled as follows:
  - If `drop_flag` is set, or `wr_ptr - rd_ptr == DEPTH`, or `cur_lines == MAX_LINES`: do not write. Set `drop_flag` and rewind `wr_ptr` to `wr_commit`.
  - Otherwise: write the line at `wr_ptr`, increment `wr_ptr`, increment `cur_lines`.
- On the tlast beat, the packet is dropped if any of these hold: `drop_flag` set, `s_axis_tuser` = 1, the length FIFO is full, or a drop condition fires on this beat.
  - Drop: `wr_ptr ← wr_commit`; `drop_count` +1.
  - Commit: `wr_commit ← wr_ptr + 1`; push `cur_lines + 1` into the length FIFO; `pkt_count` +1.
  - In both cases: `cur_lines ← 0`, `drop_flag ← 0`.
- Read side:
  - A packet may be read only while the length FIFO is non-empty and `rd_ptr != wr_commit`.
  - The RAM read is registered, feeding a 2-entry output skid register, so the output runs at full rate.
  - `m_axis_line_count` is the length-FIFO head, captured when the first beat loads into the output stage.
  - The length FIFO pops when the tlast beat is accepted at the output.
- Read and write of the same RAM address are impossible, because reads only cover committed space.

## Timing
- Reset values: `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `m_axis_tkeep` = 0, `m_axis_line_count` = 0, `pkt_count` = 0, `drop_count` = 0, `s_axis_tready` = 0. All pointers, `cur_lines`, `drop_flag` and the length FIFO are cleared.
- Reset asserted mid-packet or mid-output: all buffered data is discarded and no counters increment. After reset, the first accepted beat starts a new packet.
- Latency: with the output idle, a packet whose tlast is accepted in cycle T has `m_axis_tvalid` = 1 in cycle T+2.
- Throughput: one beat per cycle sustained while `m_axis_tready` = 1, including back-to-back packets with no bubble between tlast and the next first beat.
- Output handshake: once `m_axis_tvalid` = 1, it and all output data stay stable until accepted.
- Simultaneous commit and tlast pop in the same cycle: the length-FIFO count is unchanged.
- Space freed by reads in cycle T is visible to the full check in T+1.
- An exact fill (the packet's last line takes the final free entry) is accepted.

## Test plan
- Single 1-beat packet, tkeep = 0xFFFF_FFFF_FFFF_FFFF → one output beat with tlast = 1 and line_count = 1 at T+2; `pkt_count` = 1.
- Packets of 4, 1 and 7 lines back-to-back with `m_axis_tready` = 1 → 12 contiguous output beats; line_count reads 4, 1, 7 on every beat of its respective packet; data and tkeep match the input.
- 3-line packet with tuser = 1 on tlast, followed by a good 2-line packet → only the 2-line packet appears; `drop_count` = 1; `pkt_count` = 1.
- `DEPTH` = 16, `m_axis_tready` = 0: a 10-line packet, then an 8-line packet → the 8-line packet is dropped; then tready = 1 and a 6-line packet is sent → output is 10, then 6; `drop_count` = 1.
- `MAX_LINES` = 200: a 201-line packet → dropped, nothing output; a following 200-line packet → output with line_count = 200.
- Random `m_axis_tready` over 100 packets (scoreboard check), then `rst` asserted mid-packet → outputs return to reset values next cycle, counters = 0, and the next packet passes correctly.
